// File: rtl/demux1_4_stream_pkg.sv
// Shared widths, channel-buffer state encoding and select decode for the 1:4 stream demux.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package demux_pkg;

    localparam int DATA_WIDTH  = 64;
    localparam int NUM_OUTPUTS = 4;
    // Derived from NUM_OUTPUTS; never set independently.
    localparam int SEL_WIDTH   = $clog2(NUM_OUTPUTS);

    typedef enum logic [1:0] {
        BUF_EMPTY,
        BUF_ONE,
        BUF_TWO
    } buf_state_t;

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [SEL_WIDTH-1:0]  sel_t;

    // One-hot decode of the destination channel.
    function automatic logic [NUM_OUTPUTS-1:0] sel_decode(input sel_t sel);
        logic [NUM_OUTPUTS-1:0] w_one;
        w_one = {{(NUM_OUTPUTS-1){1'b0}}, 1'b1};
        return w_one << sel;
    endfunction

endpackage

// File: rtl/demux1_4_stream_if.sv
// Bundles the input stream and the NUM_OUTPUTS output streams of the demux.
// Latency: n/a (wiring only).
// Backpressure: in_ready / out_ready carry flow control in opposite directions.
interface demux1_4_stream_if;
    import demux_pkg::*;

    logic                              in_valid;
    logic                              in_ready;
    data_t                             in_data;
    sel_t                              in_select;
    logic [NUM_OUTPUTS-1:0]            out_valid;
    logic [NUM_OUTPUTS-1:0]            out_ready;
    logic [NUM_OUTPUTS*DATA_WIDTH-1:0] out_data;
    logic [NUM_OUTPUTS-1:0]            chan_full;

    // Demux side.
    modport slave (
        input  in_valid, in_data, in_select, out_ready,
        output in_ready, out_valid, out_data, chan_full
    );

    // Producer/consumer side.
    modport master (
        output in_valid, in_data, in_select, out_ready,
        input  in_ready, out_valid, out_data, chan_full
    );

endinterface

// File: rtl/demux1_4_stream_chan_buffer.sv
// Two-entry per-channel FIFO with EMPTY/ONE/TWO state and registered valid/full/head.
// Latency: a pushed word is visible on o_vld/o_dat one cycle after the push edge.
// Backpressure: o_full tells the steering logic to stop pushes; head held while i_pop_rdy=0.
module demux_chan_buffer
    import demux_pkg::*;
(
    input  logic  clk,
    input  logic  reset_n,
    input  logic  i_push,
    input  data_t i_push_data,
    input  logic  i_pop_rdy,
    output logic  o_vld,
    output data_t o_dat,
    output logic  o_full
);

    buf_state_t r_state;
    data_t      r_head;
    data_t      r_tail;
    logic       r_vld;
    logic       r_full;
    logic       w_pop;

    assign w_pop = r_vld & i_pop_rdy;

    // Occupancy FSM; head/tail storage and the valid/full flags move with the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= BUF_EMPTY;
            r_head  <= '0;
            r_tail  <= '0;
            r_vld   <= 1'b0;
            r_full  <= 1'b0;
        end else begin
            case (r_state)
                BUF_EMPTY: begin
                    if (i_push) begin
                        r_head  <= i_push_data;
                        r_state <= BUF_ONE;
                        r_vld   <= 1'b1;
                    end
                end
                BUF_ONE: begin
                    if (i_push && !w_pop) begin
                        r_tail  <= i_push_data;
                        r_state <= BUF_TWO;
                        r_full  <= 1'b1;
                    end else if (!i_push && w_pop) begin
                        r_state <= BUF_EMPTY;
                        r_vld   <= 1'b0;
                    end else if (i_push && w_pop) begin
                        // Old head leaves as the new word arrives: stays ONE.
                        r_head  <= i_push_data;
                    end
                end
                BUF_TWO: begin
                    // Pushes cannot arrive here: the top drops in_ready while full.
                    if (w_pop) begin
                        r_head  <= r_tail;
                        r_state <= BUF_ONE;
                        r_full  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= BUF_EMPTY;
                    r_vld   <= 1'b0;
                    r_full  <= 1'b0;
                end
            endcase
        end
    end

    assign o_vld  = r_vld;
    assign o_dat  = r_head;
    assign o_full = r_full;

endmodule

// File: rtl/demux1_4_stream.sv
// Routes one valid/ready stream to one of NUM_OUTPUTS buffered channels chosen by in_select.
// Latency: 1 cycle from accept to out_valid; no combinational input-to-output path.
// Backpressure: in_ready = !chan_full[in_select]; a stalled consumer blocks only its own channel.
module demux1_4_stream
    import demux_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    demux1_4_stream_if.slave  bus
);

    logic [NUM_OUTPUTS-1:0] w_sel_onehot;
    logic [NUM_OUTPUTS-1:0] w_push;
    logic [NUM_OUTPUTS-1:0] w_vld;
    logic [NUM_OUTPUTS-1:0] w_full;
    logic                   w_accept;

    assign w_sel_onehot = sel_decode(bus.in_select);

    // Depends only on in_select and registered full flags, never on in_valid or out_ready.
    assign bus.in_ready = ~w_full[bus.in_select];
    assign w_accept     = bus.in_valid & bus.in_ready;
    assign w_push       = w_sel_onehot & {NUM_OUTPUTS{w_accept}};

    for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_chan
        data_t w_head;

        demux_chan_buffer u_buf (
            .clk         (clk),
            .reset_n     (reset_n),
            .i_push      (w_push[g]),
            .i_push_data (bus.in_data),
            .i_pop_rdy   (bus.out_ready[g]),
            .o_vld       (w_vld[g]),
            .o_dat       (w_head),
            .o_full      (w_full[g])
        );

        assign bus.out_data[g*DATA_WIDTH +: DATA_WIDTH] = w_head;
    end

    assign bus.out_valid = w_vld;
    assign bus.chan_full = w_full;

endmodule

// File: tb/tb_demux1_4_stream.sv
// Scoreboarded bench for the 1:4 stream demux: directed scenarios plus a random soak.
// Latency: inputs driven 1 time unit after the rising edge, outputs checked before the next edge.
// Backpressure: random out_ready; the driver holds its word until in_ready accepts it.
module tb_demux1_4_stream;
    import demux_pkg::*;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;

    always #5 clk = ~clk;

    demux1_4_stream_if bus ();

    demux1_4_stream dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int    n_checks = 0;
    int    n_pass   = 0;
    data_t exp_q[NUM_OUTPUTS][$];
    logic  hold_vld[NUM_OUTPUTS];
    data_t hold_dat[NUM_OUTPUTS];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic data_t chan_dat(input int i);
        return bus.out_data[i*DATA_WIDTH +: DATA_WIDTH];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expected words on each output handshake, checks head stability while stalled,
    // and records each accepted input word into its channel queue.
    always @(negedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_OUTPUTS; i++) begin
                exp_q[i].delete();
                hold_vld[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_OUTPUTS; i++) begin
                if (hold_vld[i]) begin
                    check($sformatf("hold_valid_ch%0d", i), 64'(bus.out_valid[i]), 64'd1);
                    check($sformatf("hold_data_ch%0d", i), chan_dat(i), hold_dat[i]);
                end
                if (bus.out_valid[i] && bus.out_ready[i]) begin
                    if (exp_q[i].size() == 0) begin
                        n_checks++;
                        $display("FAIL pop_unexpected_ch%0d: got 0x%0h expected no word at %0t",
                                 i, chan_dat(i), $time);
                    end else begin
                        check($sformatf("pop_data_ch%0d", i), chan_dat(i), exp_q[i].pop_front());
                    end
                end
                hold_vld[i] = bus.out_valid[i] && !bus.out_ready[i];
                hold_dat[i] = chan_dat(i);
            end
            if (bus.in_valid && bus.in_ready)
                exp_q[bus.in_select].push_back(bus.in_data);
        end
    end

    logic        acc;
    int unsigned seq;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_select = '0;
        bus.out_ready = '0;
        acc           = 1'b0;
        seq           = 0;

        // Reset state
        #2 reset_n = 1'b0;
        tick();
        tick();
        check("rst_out_valid", 64'(bus.out_valid), 64'h0);
        check("rst_chan_full", 64'(bus.chan_full), 64'h0);
        check("rst_out_data_nz", 64'(|bus.out_data), 64'h0);
        check("rst_in_ready", 64'(bus.in_ready), 64'h1);
        reset_n = 1'b1;
        tick();

        // Routing: each channel gets one word, visible for exactly one cycle
        bus.out_ready = 4'hF;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            bus.in_data   = 64'hA0 + 64'(i);
            bus.in_select = sel_t'(i);
            tick();
            check($sformatf("route_valid_%0d", i), 64'(bus.out_valid), 64'(4'b0001 << i));
            check($sformatf("route_data_%0d", i), chan_dat(i), 64'hA0 + 64'(i));
        end
        bus.in_valid = 1'b0;
        tick();
        check("route_idle", 64'(bus.out_valid), 64'h0);

        // Back-pressure on channel 2
        bus.out_ready = 4'b1011;
        bus.in_valid  = 1'b1;
        bus.in_select = 2'd2;
        bus.in_data   = 64'h11;
        #1 check("bp_rdy_first", 64'(bus.in_ready), 64'h1);
        tick();
        bus.in_data = 64'h22;
        #1 check("bp_rdy_second", 64'(bus.in_ready), 64'h1);
        tick();
        check("bp_full", 64'(bus.chan_full), 64'h4);
        check("bp_head", chan_dat(2), 64'h11);
        bus.in_data = 64'h33;
        #1 check("bp_rdy_blocked", 64'(bus.in_ready), 64'h0);
        tick();
        check("bp_still_full", 64'(bus.chan_full), 64'h4);
        check("bp_still_blocked", 64'(bus.in_ready), 64'h0);
        bus.in_valid  = 1'b0;
        bus.in_select = 2'd1;
        bus.in_data   = 64'h44;
        #1 check("bp_rdy_ch1", 64'(bus.in_ready), 64'h1);
        bus.in_valid = 1'b1;
        tick();
        check("bp_ch1_valid", 64'(bus.out_valid[1]), 64'h1);
        check("bp_ch1_data", chan_dat(1), 64'h44);
        bus.in_select = 2'd2;
        bus.in_data   = 64'h33;
        bus.out_ready = 4'hF;
        #1 check("bp_full_pop_rdy", 64'(bus.in_ready), 64'h0);
        tick();
        check("bp_drain_full", 64'(bus.chan_full), 64'h0);
        check("bp_drain_head", chan_dat(2), 64'h22);
        check("bp_drain_rdy", 64'(bus.in_ready), 64'h1);
        tick();
        check("bp_third_head", chan_dat(2), 64'h33);
        check("bp_third_valid", 64'(bus.out_valid), 64'h4);
        bus.in_valid = 1'b0;
        tick();
        check("bp_idle", 64'(bus.out_valid), 64'h0);

        // Simultaneous push and pop on a ONE-state channel
        bus.out_ready = 4'b1110;
        bus.in_valid  = 1'b1;
        bus.in_select = 2'd0;
        bus.in_data   = 64'h50;
        tick();
        check("pp_one_valid", 64'(bus.out_valid), 64'h1);
        bus.in_data   = 64'h55;
        bus.out_ready = 4'hF;
        tick();
        check("pp_valid", 64'(bus.out_valid), 64'h1);
        check("pp_head", chan_dat(0), 64'h55);
        check("pp_not_full", 64'(bus.chan_full), 64'h0);
        bus.in_valid = 1'b0;
        tick();
        check("pp_idle", 64'(bus.out_valid), 64'h0);

        // Full channel popped while a push waits: no pass-through
        bus.out_ready = 4'b0111;
        bus.in_valid  = 1'b1;
        bus.in_select = 2'd3;
        bus.in_data   = 64'h61;
        tick();
        bus.in_data = 64'h62;
        tick();
        check("fp_full", 64'(bus.chan_full), 64'h8);
        check("fp_head", chan_dat(3), 64'h61);
        bus.in_data   = 64'h63;
        bus.out_ready = 4'hF;
        #1 check("fp_rdy_low", 64'(bus.in_ready), 64'h0);
        tick();
        check("fp_one_full", 64'(bus.chan_full), 64'h0);
        check("fp_one_head", chan_dat(3), 64'h62);
        check("fp_rdy_high", 64'(bus.in_ready), 64'h1);
        tick();
        check("fp_push_head", chan_dat(3), 64'h63);
        check("fp_push_valid", 64'(bus.out_valid), 64'h8);
        bus.in_valid = 1'b0;
        tick();
        check("fp_idle", 64'(bus.out_valid), 64'h0);

        // Reset with words buffered
        bus.out_ready = 4'h0;
        bus.in_valid  = 1'b1;
        bus.in_select = 2'd0;
        bus.in_data   = 64'h71;
        tick();
        bus.in_select = 2'd1;
        bus.in_data   = 64'h72;
        tick();
        bus.in_data = 64'h73;
        tick();
        bus.in_valid = 1'b0;
        check("mr_pre_full", 64'(bus.chan_full), 64'h2);
        check("mr_pre_valid", 64'(bus.out_valid), 64'h3);
        reset_n = 1'b0;
        #1;
        check("mr_valid", 64'(bus.out_valid), 64'h0);
        check("mr_full", 64'(bus.chan_full), 64'h0);
        check("mr_data_nz", 64'(|bus.out_data), 64'h0);
        tick();
        reset_n = 1'b1;
        #1 check("mr_rdy", 64'(bus.in_ready), 64'h1);
        bus.out_ready = 4'hF;
        tick();
        check("mr_no_replay", 64'(bus.out_valid), 64'h0);

        // Random soak; a word is held until accepted
        for (int c = 0; c < 10000; c++) begin
            if (!bus.in_valid || acc) begin
                bus.in_valid  = ($urandom_range(0, 3) != 0);
                bus.in_select = sel_t'($urandom_range(0, NUM_OUTPUTS-1));
                bus.in_data   = {8'(bus.in_select), 24'h5A5A5A, 32'(seq)};
                seq++;
            end
            bus.out_ready = 4'($urandom);
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'hF;
        repeat (4) tick();
        for (int i = 0; i < NUM_OUTPUTS; i++)
            check($sformatf("drain_empty_ch%0d", i), 64'(exp_q[i].size()), 64'h0);
        check("drain_valid", 64'(bus.out_valid), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
